// File: rtl/tagged_fifo_27.sv
// Tag-demultiplexed FIFO bank: one tagged write stream fans out into FLUX circular
// buffers, read back through a lowest-index-first, first-word-fall-through output.
module tagged_fifo_27 #(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 27,
`ifdef MONO
    parameter int unsigned TAG_WIDTH  = 0,
`else
    parameter int unsigned TAG_WIDTH  = $clog2(FLUX),
`endif
    localparam int unsigned WIDTH     = DATA_WIDTH + TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] din,
    output logic [FLUX-1:0]  full,
    input  logic [FLUX-1:0]  read,
    output logic [FLUX-1:0]  empty,
    output logic [WIDTH-1:0] dout,
    output logic             err
);

    localparam int unsigned TW1 = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FLUX][DEPTH];
    logic [PW-1:0]         wptr_q [FLUX];
    logic [PW-1:0]         wptr_d [FLUX];
    logic [PW-1:0]         rptr_q [FLUX];
    logic [PW-1:0]         rptr_d [FLUX];
    logic [CW-1:0]         cnt_q  [FLUX];
    logic [CW-1:0]         cnt_d  [FLUX];
    logic                  err_q, err_d;

    logic [TW1-1:0]        wr_tag;
    logic [TW1-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  multi_rd;
    logic                  tag_ok;
    logic                  sel_full;
    logic                  sel_empty;
    logic [FLUX-1:0]       push_en;
    logic [FLUX-1:0]       pop_en;

    assign wr_data = din[DATA_WIDTH-1:0];

    generate
        if (TAG_WIDTH == 0) begin : g_notag
            assign wr_tag = '0;
            assign dout   = rd_data;
        end else begin : g_tag
            assign wr_tag = din[WIDTH-1 -: TAG_WIDTH];
            assign dout   = rd_valid ? {rd_idx, rd_data} : '0;
        end
    endgenerate

    // Flags come only from registered counts so upstream can derive write/read from them.
    always_comb begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            full[i]  = (cnt_q[i] == CW'(DEPTH));
            empty[i] = (cnt_q[i] == '0);
        end
    end

    always_comb begin
        rd_valid = |read;
        multi_rd = |(read & (read - FLUX'(1)));
        rd_idx   = '0;
        for (int unsigned i = FLUX; i > 0; i--) begin
            if (read[i-1]) rd_idx = TW1'(i - 1);
        end

        tag_ok    = (32'(wr_tag) < FLUX);
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        rd_data   = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (wr_tag == TW1'(i)) sel_full = full[i];
            if (rd_idx == TW1'(i)) sel_empty = empty[i];
            if (rd_valid && rd_idx == TW1'(i)) rd_data = mem_q[i][rptr_q[i]];
            push_en[i] = write && tag_ok && (wr_tag == TW1'(i)) && !full[i];
            pop_en[i]  = rd_valid && (rd_idx == TW1'(i)) && !empty[i];
        end

        err_d = err_q
              | (write && (!tag_ok || sel_full))
              | (rd_valid && sel_empty)
              | multi_rd;
    end

    always_comb begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            cnt_d[i]  = cnt_q[i];
            if (push_en[i])
                wptr_d[i] = (wptr_q[i] == PW'(DEPTH - 1)) ? '0 : wptr_q[i] + PW'(1);
            if (pop_en[i])
                rptr_d[i] = (rptr_q[i] == PW'(DEPTH - 1)) ? '0 : rptr_q[i] + PW'(1);
            case ({push_en[i], pop_en[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    // Storage is deliberately left out of reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (push_en[i]) mem_q[i][wptr_q[i]] <= wr_data;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_tagged_fifo_27.sv
// Directed bench for tagged_fifo_27 (FLUX=2, DEPTH=4, 27-bit data, 1-bit tag).
module tb_tagged_fifo_27;

    localparam int unsigned W = 28;

    logic         clk = 1'b0;
    logic         rst;
    logic         write;
    logic [W-1:0] din;
    logic [1:0]   full;
    logic [1:0]   read;
    logic [1:0]   empty;
    logic [W-1:0] dout;
    logic         err;

    int n_vec  = 0;
    int n_miss = 0;

    tagged_fifo_27 #(.FLUX(2), .DEPTH(4), .DATA_WIDTH(27)) dut (
        .clk   (clk),
        .rst   (rst),
        .write (write),
        .din   (din),
        .full  (full),
        .read  (read),
        .empty (empty),
        .dout  (dout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] word(input logic tag, input int unsigned v);
        return {tag, 27'(v)};
    endfunction

    task automatic push(input logic tag, input int unsigned v);
        write = 1'b1;
        din   = word(tag, v);
        step();
        write = 1'b0;
        din   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        write = 1'b0;
        din   = '0;
        read  = '0;
        #12;
        check("rst_empty", 32'(empty), 32'h3);
        check("rst_full",  32'(full),  32'h0);
        check("rst_err",   32'(err),   32'h0);
        check("rst_dout",  32'(dout),  32'h0);
        rst = 1'b0;
        step();

        // single push to flux 1
        push(1'b1, 5);
        check("t1_empty", 32'(empty), 32'h1);
        check("t1_full",  32'(full),  32'h0);
        read = 2'b10;
        #1;
        check("t1_dout", 32'(dout), 32'(word(1'b1, 5)));
        step();
        read = 2'b00;
        #1;
        check("t1_empty_after", 32'(empty), 32'h3);
        check("t1_dout_idle",   32'(dout),  32'h0);
        check("t1_err",         32'(err),   32'h0);

        // fill flux 0, overflow, drain
        for (int unsigned k = 1; k <= 4; k++) push(1'b0, k);
        check("t2_full",  32'(full),  32'h1);
        check("t2_empty", 32'(empty), 32'h2);
        check("t2_err0",  32'(err),   32'h0);
        push(1'b0, 5);
        check("t2_ovf_err",  32'(err),  32'h1);
        check("t2_ovf_full", 32'(full), 32'h1);
        read = 2'b01;
        for (int unsigned k = 1; k <= 4; k++) begin
            #1;
            check("t2_pop", 32'(dout), 32'(word(1'b0, k)));
            if (k == 1) begin
                step();
                check("t2_full_fall", 32'(full), 32'h0);
            end else begin
                step();
            end
        end
        read = 2'b00;
        #1;
        check("t2_empty_end", 32'(empty), 32'h3);
        check("t2_err_sticky", 32'(err), 32'h1);

        do_reset();
        check("t3_err_clr", 32'(err), 32'h0);

        // wrap-around on flux 1 with concurrent push/pop at count 2
        push(1'b1, 10);
        push(1'b1, 11);
        for (int unsigned k = 12; k <= 15; k++) begin
            write = 1'b1;
            din   = word(1'b1, k);
            read  = 2'b10;
            #1;
            check("t3_conc_pop", 32'(dout), 32'(word(1'b1, k - 2)));
            step();
            check("t3_full",  32'(full),  32'h0);
            check("t3_empty", 32'(empty), 32'h1);
        end
        write = 1'b0;
        din   = '0;
        for (int unsigned k = 14; k <= 15; k++) begin
            #1;
            check("t3_drain", 32'(dout), 32'(word(1'b1, k)));
            step();
        end
        read = 2'b00;
        #1;
        check("t3_empty_end", 32'(empty), 32'h3);
        check("t3_err",       32'(err),   32'h0);

        // interleaved fluxes
        push(1'b0, 100);
        push(1'b1, 200);
        push(1'b0, 101);
        push(1'b1, 201);
        check("t4_empty", 32'(empty), 32'h0);
        read = 2'b01;
        #1; check("t4_f0a", 32'(dout), 32'(word(1'b0, 100))); step();
        #1; check("t4_f0b", 32'(dout), 32'(word(1'b0, 101))); step();
        read = 2'b10;
        #1; check("t4_f1a", 32'(dout), 32'(word(1'b1, 200))); step();
        #1; check("t4_f1b", 32'(dout), 32'(word(1'b1, 201))); step();
        read = 2'b00;
        #1;
        check("t4_empty_end", 32'(empty), 32'h3);
        check("t4_err",       32'(err),   32'h0);

        // multi-read with flux 0 empty: flux 0 wins, underflows
        push(1'b1, 7);
        read = 2'b11;
        #1;
        check("t5_tag", 32'(dout[27]), 32'h0);
        step();
        read = 2'b00;
        #1;
        check("t5_err",   32'(err),   32'h1);
        check("t5_empty", 32'(empty), 32'h1);
        read = 2'b10;
        #1;
        check("t5_f1", 32'(dout), 32'(word(1'b1, 7)));
        step();
        read = 2'b00;
        #1;

        // asynchronous reset mid-stream
        do_reset();
        for (int unsigned k = 1; k <= 3; k++) push(1'b0, 20 + k);
        check("t6_pre_empty", 32'(empty), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_empty", 32'(empty), 32'h3);
        check("t6_async_full",  32'(full),  32'h0);
        check("t6_async_err",   32'(err),   32'h0);
        rst = 1'b0;
        step();
        push(1'b1, 42);
        check("t6_post_empty", 32'(empty), 32'h1);
        read = 2'b10;
        #1;
        check("t6_post_dout", 32'(dout), 32'(word(1'b1, 42)));
        step();
        read = 2'b00;
        #1;
        check("t6_post_end", 32'(empty), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tagged_fifo_27.md
# tagged_fifo_27

Per-flux FIFO bank that sits directly downstream of the 27-bit adder actor in the 8-pixel HEVC multi-dataflow datapath. It accepts the adder's single tagged write stream, demultiplexes each word by tag into one of FLUX independent circular buffers, and exposes per-flux full/empty flags plus a read-selected, first-word-fall-through output to the next actor. It provides the buffering and backpressure that let multiple interleaved data fluxes share one combinational actor.

## Interface
- FLUX, 2: number of independent data fluxes (≥1).
- DEPTH, 4: entries per flux buffer (≥2, any integer, not restricted to powers of 2).
- DATA_WIDTH, 27: payload width.
- TAG_WIDTH, $clog2(FLUX), forced to 0 when `MONO` is defined; WIDTH = DATA_WIDTH+TAG_WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- write  in  1  producer push strobe.
- din  in  WIDTH  {tag[TAG_WIDTH-1:0], data[DATA_WIDTH-1:0]}; tag selects target flux.
- full  out  FLUX  full[i]=1 when flux i holds DEPTH words.
- read  in  FLUX  consumer pop strobes, at most one bit set per cycle.
- empty  out  FLUX  empty[i]=1 when flux i holds 0 words.
- dout  out  WIDTH  {i, head word of flux i} for the flux whose read bit is set.
- err  out  1  sticky protocol-error flag.
- Flat ports map 1:1 onto the fifo side of write_interface (write, din, full) and read_interface (read, empty, dout).

## Operation
- Per flux i: storage array DEPTH×DATA_WIDTH, write pointer, read pointer (0..DEPTH-1, wrap to 0 after DEPTH-1), occupancy count 0..DEPTH.
- Push: write=1, tag<FLUX, full[tag]=0 → store data at wptr[tag], advance wptr[tag], count+1.
- Pop: read[i]=1, empty[i]=0 → advance rptr[i], count-1.
- Simultaneous push and pop on same flux: both performed, count unchanged; allowed at count=DEPTH only for the pop (push refused, full is from pre-edge count) and at count=0 only for the push (pop refused).
- Push and pop on different fluxes in the same cycle: independent.
- Error cases (word dropped / pop ignored, state otherwise unchanged, err set to 1 and held until reset):
  - write=1 with full[tag]=1 (overflow).
  - write=1 with tag≥FLUX (only possible when FLUX is not a power of 2).
  - read[i]=1 with empty[i]=1 (underflow).
  - more than one read bit set: only the lowest-index set bit is serviced.
- dout is combinational from read: tag field = index of lowest set read bit, data field = that flux's head word (first-word fall-through). With no read bit set, dout = 0.
- MONO (TAG_WIDTH=0): FLUX must be 1; all writes go to flux 0; dout = data only.
- full/empty are decoded from registered counts only; they never depend combinationally on write/read (no comb loop with the adder, which derives read/write from these flags).

## Timing
- Reset (async assert, synchronous-release expected upstream): all counts 0, pointers 0, empty = all 1, full = all 0, err = 0, dout = 0. Storage contents not reset (don't care).
- Reset asserted mid-operation: all buffered words discarded immediately; flags reach reset values without waiting for a clock edge.
- Write latency: word pushed at edge k → empty[tag]=0 and word visible on dout (when read) in cycle after edge k.
- Read latency: zero; dout valid in the same cycle read[i] is asserted, pop takes effect at the following edge.
- full[i] rises in the cycle after the DEPTH-th push; falls in the cycle after a pop with no concurrent push.
- Throughput: one push and one pop per cycle sustained per flux and across fluxes.

## Test plan
- Reset then single push din={1'b1,27'd5} → after 1 edge empty=2'b01, full=2'b00; read=2'b10 gives dout={1,27'd5}; after edge empty=2'b11.
- Fill flux 0 with 4 words 1,2,3,4 (DEPTH=4) → full=2'b01 after 4th edge; 5th push of 5 dropped, err=1; pops return 1,2,3,4 in order, then empty[0]=1.
- Wrap-around: 6 push/pop cycles on flux 1 with concurrent push and pop at count=2 → count stays 2, output order preserved 10..15 across pointer wrap.
- Interleaved fluxes: alternate tags 0,1,0,1 with values 100,200,101,201 → flux 0 pops 100,101, flux 1 pops 200,201; no cross-contamination, err=0.
- Underflow and multi-read: read=2'b11 with only flux 1 non-empty → flux 0 serviced (underflow), flux 1 untouched, dout tag=0, err=1.
- Reset mid-stream with flux 0 holding 3 words → empty=2'b11, full=2'b00, err=0 asynchronously; subsequent push/pop behaves as from fresh reset.
